// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32M constants and muldiv sequencer state type
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } muldiv_state_t;

  // Divide/remainder ops all have funct3[2] set.
  function automatic logic isDivOp(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/execute_muldiv_seq_if.sv
// rtl/execute_muldiv_seq_if.sv - execute-stage to muldiv sequencer handshake bundle
interface execute_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            StartE;
  logic [2:0]      Funct3E;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            FlushE;
  logic            StallMD;
  logic            DoneMD;
  logic [XLEN-1:0] ResultMD;

  modport master (
    output StartE, Funct3E, SrcAE, SrcBE, FlushE,
    input  StallMD, DoneMD, ResultMD
  );

  modport slave (
    input  StartE, Funct3E, SrcAE, SrcBE, FlushE,
    output StallMD, DoneMD, ResultMD
  );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply or restoring-divide iteration
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              isDiv,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   bMag,
  output logic [2*XLEN-1:0] accNext
);

  // Multiply: acc = {partial product high, remaining multiplier bits}; add then shift right.
  // Divide:   acc = {remainder, dividend/quotient}; shift left, trial-subtract divisor.
  logic [XLEN:0]   mulSum;
  logic            divGe;
  logic [XLEN-1:0] divRem;

  // Single combinational iteration for either op class
  always_comb begin
    mulSum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? bMag : '0)};
    divGe   = acc[2*XLEN-1:XLEN-1] >= {1'b0, bMag};
    divRem  = acc[2*XLEN-2:XLEN-1] - bMag;
    accNext = {mulSum, acc[XLEN-1:1]};
    if (isDiv) begin
      if (divGe) accNext = {divRem, acc[XLEN-2:0], 1'b1};
      else       accNext = {acc[2*XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/execute_muldiv_seq.sv
// rtl/execute_muldiv_seq.sv - iterative RV32M sequencer; optional MULDIV_EARLY_OUT_EN
module execute_muldiv_seq
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input logic                  clk,
  input logic                  rst_n,
  execute_muldiv_seq_if.slave  mdIf
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  muldiv_state_t     state, stateNext;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3Q;
  logic [2*XLEN-1:0] acc, accNext;
  logic [XLEN-1:0]   bMag, aOrig, resultQ;
  logic              sA, sB, bZero;

  logic              accept;
  logic              inSA, inSB;
  logic [XLEN-1:0]   inAMag, inBMag;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, finalRes;

  assign accept = (state == MD_IDLE) && mdIf.StartE && !mdIf.FlushE;

  // Operand signedness and magnitudes at acceptance (MULHSU: A signed, B unsigned)
  always_comb begin
    inSA   = ((mdIf.Funct3E == F3_MULH) || (mdIf.Funct3E == F3_MULHSU) ||
              (mdIf.Funct3E == F3_DIV)  || (mdIf.Funct3E == F3_REM)) && mdIf.SrcAE[XLEN-1];
    inSB   = ((mdIf.Funct3E == F3_MULH) || (mdIf.Funct3E == F3_DIV) ||
              (mdIf.Funct3E == F3_REM)) && mdIf.SrcBE[XLEN-1];
    inAMag = inSA ? -mdIf.SrcAE : mdIf.SrcAE;
    inBMag = inSB ? -mdIf.SrcBE : mdIf.SrcBE;
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic            earlyHit;
  logic [XLEN-1:0] earlyRes;

  // Special cases resolvable from the raw operands without iterating
  always_comb begin
    earlyHit = 1'b0;
    earlyRes = '0;
    if (isDivOp(mdIf.Funct3E)) begin
      if (mdIf.SrcBE == '0) begin
        earlyHit = 1'b1;
        earlyRes = mdIf.Funct3E[1] ? mdIf.SrcAE : '1;
      end else if (!mdIf.Funct3E[0] && (mdIf.SrcAE == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (mdIf.SrcBE == '1)) begin
        earlyHit = 1'b1;
        earlyRes = mdIf.Funct3E[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end
    end else if ((mdIf.SrcAE == '0) || (mdIf.SrcBE == '0)) begin
      earlyHit = 1'b1;
    end
  end
`endif

  muldiv_step #(.XLEN(XLEN)) uStep (
    .isDiv   (isDivOp(f3Q)),
    .acc     (acc),
    .bMag    (bMag),
    .accNext (accNext)
  );

  // Sign fix-up of the last iteration's output; divide-by-zero overrides the quotient/remainder
  always_comb begin
    prod = (sA ^ sB) ? -accNext : accNext;
    quo  = (sA ^ sB) ? -accNext[XLEN-1:0] : accNext[XLEN-1:0];
    rem  = sA ? -accNext[2*XLEN-1:XLEN] : accNext[2*XLEN-1:XLEN];
    if (isDivOp(f3Q)) begin
      if (bZero) finalRes = f3Q[1] ? aOrig : '1;
      else       finalRes = f3Q[1] ? rem : quo;
    end else begin
      finalRes = (f3Q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= stateNext;
  end

  // FSM next state and handshake outputs; flush wins over start and over completion
  always_comb begin
    stateNext    = state;
    mdIf.StallMD = 1'b0;
    mdIf.DoneMD  = 1'b0;
    case (state)
      MD_IDLE: begin
        if (accept) begin
`ifdef MULDIV_EARLY_OUT_EN
          stateNext = earlyHit ? MD_DONE : MD_CALC;
`else
          stateNext = MD_CALC;
`endif
        end
      end
      MD_CALC: begin
        if (mdIf.FlushE)             stateNext = MD_IDLE;
        else if (cnt == CNT_W'(1))   stateNext = MD_DONE;
      end
      MD_DONE: stateNext = MD_IDLE;
      default: stateNext = MD_IDLE;
    endcase
    mdIf.StallMD = rst_n && (accept || (state == MD_CALC));
    mdIf.DoneMD  = rst_n && (state == MD_DONE) && !mdIf.FlushE;
  end

  // Datapath: operand capture on acceptance, one iteration per CALC cycle, result load at the end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      f3Q     <= '0;
      acc     <= '0;
      bMag    <= '0;
      aOrig   <= '0;
      sA      <= 1'b0;
      sB      <= 1'b0;
      bZero   <= 1'b0;
      resultQ <= '0;
    end else if (accept) begin
      cnt   <= CNT_W'(XLEN);
      f3Q   <= mdIf.Funct3E;
      acc   <= {{XLEN{1'b0}}, inAMag};
      bMag  <= inBMag;
      aOrig <= mdIf.SrcAE;
      sA    <= inSA;
      sB    <= inSB;
      bZero <= (mdIf.SrcBE == '0);
`ifdef MULDIV_EARLY_OUT_EN
      if (earlyHit) resultQ <= earlyRes;
`endif
    end else if ((state == MD_CALC) && !mdIf.FlushE) begin
      acc <= accNext;
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) resultQ <= finalRes;
    end
  end

  assign mdIf.ResultMD = resultQ;

endmodule

// File: tb/tb_execute_muldiv_seq.sv
// tb/tb_execute_muldiv_seq.sv - directed vector bench for execute_muldiv_seq
module tb_execute_muldiv_seq;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  execute_muldiv_seq_if #(.XLEN(32)) mdIf ();
  execute_muldiv_seq #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .mdIf(mdIf));

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  vec_t vecs[18];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic waitDone(input string name, input int expLat, input logic [31:0] expRes);
    int lat = 0;
    bit stallOk = 1'b1;
    chk({name, " stall@0"}, {31'b0, mdIf.StallMD}, 32'd1);
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (mdIf.DoneMD) begin
        lat = c;
        break;
      end
      if (!mdIf.StallMD) stallOk = 1'b0;
    end
    chk({name, " latency"}, lat, expLat);
    chk({name, " stall held"}, {31'b0, stallOk}, 32'd1);
    chk({name, " result"}, mdIf.ResultMD, expRes);
    chk({name, " stall in done"}, {31'b0, mdIf.StallMD}, 32'd0);
    @(negedge clk);
    mdIf.StartE = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input int expLat, input logic [31:0] expRes);
    @(negedge clk);
    mdIf.StartE  = 1'b1;
    mdIf.Funct3E = f3;
    mdIf.SrcAE   = a;
    mdIf.SrcBE   = b;
    #1;
    waitDone(name, expLat, expRes);
  endtask

  initial begin
    int pulses;
    vecs[0]  = '{F3_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[3]  = '{F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[5]  = '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[6]  = '{F3_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
    vecs[7]  = '{F3_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[8]  = '{F3_DIVU,   32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{F3_REMU,   32'h12345678, 32'h00000000, 32'h12345678, 1'b1};
    vecs[10] = '{F3_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 1'b0};
    vecs[11] = '{F3_REMU,   32'h00000064, 32'h00000007, 32'h00000002, 1'b0};
    vecs[12] = '{F3_MUL,    32'h00000000, 32'h00000005, 32'h00000000, 1'b1};
    vecs[13] = '{F3_MULH,   32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 1'b0};
    vecs[14] = '{F3_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    vecs[15] = '{F3_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[16] = '{F3_REM,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1'b1};
    vecs[17] = '{F3_MULHU,  32'h00012345, 32'h00010000, 32'h00000001, 1'b0};

    rst_n        = 1'b0;
    mdIf.StartE  = 1'b0;
    mdIf.FlushE  = 1'b0;
    mdIf.Funct3E = 3'b000;
    mdIf.SrcAE   = '0;
    mdIf.SrcBE   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ResultMD", mdIf.ResultMD, 32'h0);
    chk("reset DoneMD", {31'b0, mdIf.DoneMD}, 32'd0);
    chk("reset StallMD", {31'b0, mdIf.StallMD}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
            (vecs[i].special && EARLY) ? 1 : 33, vecs[i].exp);
    end

    // Flush in CALC: no DoneMD, result keeps vec17's value, next op accepted immediately
    @(negedge clk);
    mdIf.StartE  = 1'b1;
    mdIf.Funct3E = F3_DIVU;
    mdIf.SrcAE   = 32'h00000064;
    mdIf.SrcBE   = 32'h00000007;
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (mdIf.DoneMD) pulses++;
    end
    chk("flush stall@10", {31'b0, mdIf.StallMD}, 32'd1);
    @(negedge clk);
    mdIf.FlushE = 1'b1;
    mdIf.StartE = 1'b0;
    #1;
    if (mdIf.DoneMD) pulses++;
    @(posedge clk); #1;
    if (mdIf.DoneMD) pulses++;
    mdIf.FlushE = 1'b0;
    chk("flush idle stall@11", {31'b0, mdIf.StallMD}, 32'd0);
    chk("flush result held", mdIf.ResultMD, 32'h00000001);
    chk("flush no done", pulses, 0);
    runOp("post-flush MUL", F3_MUL, 32'd2, 32'd3, 33, 32'd6);

    // Reset mid-MULHU, StartE held through release
    @(negedge clk);
    mdIf.StartE  = 1'b1;
    mdIf.Funct3E = F3_MULHU;
    mdIf.SrcAE   = 32'hFFFFFFFF;
    mdIf.SrcBE   = 32'hFFFFFFFF;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst DoneMD", {31'b0, mdIf.DoneMD}, 32'd0);
    chk("midrst ResultMD", mdIf.ResultMD, 32'h0);
    chk("midrst StallMD", {31'b0, mdIf.StallMD}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    waitDone("rst rerun", 33, 32'hFFFFFFFE);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
